// File: rtl/rom_seq_pkg.sv
// Shared types and constants for the ROM-path sequencer: FSM states, LFSR
// shape, datapath select widths and the rom6 range reduction.
package rom_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDrive,
    StSettle,
    StEmit,
    StFinish
  } state_e;

  localparam int unsigned LfsrWidth = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 as state-bit taps 7, 5, 4, 3
  localparam logic [LfsrWidth-1:0] LfsrTaps  = 8'hB8;
  localparam logic [LfsrWidth-1:0] LfsrReset = 8'h01;

  localparam int unsigned Rom1SelW  = 5;
  localparam int unsigned RomSelW   = 2;
  localparam int unsigned Rom6SelW  = 3;
  localparam int unsigned Rom6Range = 5;

  function automatic logic [Rom6SelW-1:0] rom6_reduce(input logic [Rom6SelW-1:0] v);
    return (v >= Rom6SelW'(Rom6Range)) ? v - Rom6SelW'(Rom6Range) : v;
  endfunction

endpackage

// File: rtl/sel_lfsr.sv
// Select-generating LFSR: seed load (zero seed forced to 1), Fibonacci advance,
// and rom6 select folded into 0..4.
module sel_lfsr
  import rom_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LfsrWidth-1:0] seed,
  input  logic                 advance,
  output logic [LfsrWidth-1:0] lfsr,
  output logic [Rom6SelW-1:0]  rom6_sel
);

  logic [LfsrWidth-1:0] lfsr_q;
  logic                 feedback;

  always_comb begin
    feedback = ^(lfsr_q & LfsrTaps);
    lfsr     = lfsr_q;
    rom6_sel = rom6_reduce(lfsr_q[Rom6SelW-1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LfsrReset;
    end else if (load) begin
      lfsr_q <= (seed == '0) ? LfsrReset : seed;
    end else if (advance) begin
      lfsr_q <= {lfsr_q[LfsrWidth-2:0], feedback};
    end
  end

endmodule

// File: rtl/rom_path_sequencer.sv
// Sequencer for the six-ROM datapath: steps rom1 selects, draws the rest from
// an LFSR, captures results and streams them out. RESULT_CHECKSUM_EN adds chk.
module rom_path_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned SIZE          = 32,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned MAX_STEPS     = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4:0]          cfg_count,
  input  logic [7:0]          cfg_seed,
  output logic [Rom1SelW-1:0] rom1_sel,
  output logic [RomSelW-1:0]  rom2_sel,
  output logic [RomSelW-1:0]  rom3_sel,
  output logic [RomSelW-1:0]  rom4_sel,
  output logic [RomSelW-1:0]  rom5_sel,
  output logic [Rom6SelW-1:0] rom6_sel,
  input  logic [SIZE-1:0]     dp_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [SIZE-1:0]     res_data,
  output logic [4:0]          res_index,
  output logic                busy,
  output logic                done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [SIZE-1:0]     chk
`endif
);

  localparam int unsigned SettleW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  state_e               state_q;
  logic [4:0]           n_q;
  logic [4:0]           idx_q;
  logic [SettleW-1:0]   settle_q;
  logic [4:0]           n_clamp;
  logic                 start_ok;
  logic                 lfsr_adv;
  logic [LfsrWidth-1:0] lfsr;
  logic [Rom6SelW-1:0]  rom6_next;

  always_comb begin
    n_clamp  = (32'(cfg_count) > MAX_STEPS) ? 5'(MAX_STEPS) : cfg_count;
    // done is high during the first idle cycle; a start there is dropped
    start_ok = start && (state_q == StIdle) && !done;
    lfsr_adv = (state_q == StDrive);
  end

  sel_lfsr u_sel_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (start_ok),
    .seed     (cfg_seed),
    .advance  (lfsr_adv),
    .lfsr     (lfsr),
    .rom6_sel (rom6_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      n_q       <= '0;
      idx_q     <= '0;
      settle_q  <= '0;
      rom1_sel  <= '0;
      rom2_sel  <= '0;
      rom3_sel  <= '0;
      rom4_sel  <= '0;
      rom5_sel  <= '0;
      rom6_sel  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
      chk       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            n_q     <= n_clamp;
            idx_q   <= '0;
            busy    <= 1'b1;
`ifdef RESULT_CHECKSUM_EN
            chk     <= '0;
`endif
            state_q <= (n_clamp == '0) ? StFinish : StDrive;
          end
        end
        StDrive: begin
          rom1_sel <= idx_q;
          rom2_sel <= lfsr[1:0];
          rom3_sel <= lfsr[3:2];
          rom4_sel <= lfsr[5:4];
          rom5_sel <= lfsr[7:6];
          rom6_sel <= rom6_next;
          settle_q <= '0;
          state_q  <= StSettle;
        end
        StSettle: begin
          if (settle_q == SettleLast) begin
            res_data  <= dp_result;
            res_index <= idx_q;
            res_valid <= 1'b1;
            state_q   <= StEmit;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        StEmit: begin
          if (res_ready) begin
            res_valid <= 1'b0;
`ifdef RESULT_CHECKSUM_EN
            chk       <= chk ^ res_data;
`endif
            if (idx_q == n_q - 5'd1) begin
              state_q <= StFinish;
            end else begin
              idx_q   <= idx_q + 5'd1;
              state_q <= StDrive;
            end
          end
        end
        StFinish: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
